allocator_rr_param: RTL
=======================

ALLOCATOR_RR_PARAM -- requirements
Module: allocator_rr_param

Interface
REQ-001 Parameter N_IN, default 4: number of switch input ports arbitrated (1..16).
REQ-002 Parameter FLIT_W, default 80: flit width in bits.
REQ-003 Parameter FTYPE_W, default 2: flit-type field width, at flit bits [FTYPE_W-1:0]; codes are the ENC_HEAD/ENC_PAYL/ENC_TAIL/ENC_SING macros from noc_parameters.v.
REQ-004 Parameter PORT_W, default 2: output-port ID field width, at flit bits [FTYPE_W+PORT_W-1:FTYPE_W].
REQ-005 Parameter WDOG_CYC, default 255: watchdog stall limit in cycles (1..65535).
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 which_port  in  PORT_W  ID of the output port this allocator serves; static.
REQ-009 flit_in  in  N_IN*FLIT_W  input flits, input i at bits [i*FLIT_W +: FLIT_W].
REQ-010 valid_in  in  N_IN  per-input flit valid.
REQ-011 busy_in  in  1  downstream output buffer full.
REQ-012 select  out  N_IN  one-hot-or-zero crossbar mux select.
REQ-013 valid_out  out  1  flit presented at the output port.
REQ-014 not_accept  out  N_IN  per-input backpressure: the flit was not taken this cycle.
REQ-015 shift_ctl  out  1  high when a new grant is issued this cycle (path-field trim).
REQ-016 lock_out  out  N_IN  registered packet-ownership vector (last_sel).
REQ-017 wdog_err  out  1  sticky watchdog error (see Configuration).

Function
REQ-018 Per input i: request[i] = valid_in[i] & type is HEAD or SING & dest field == which_port.
REQ-019 avail = (lock == 0) & !busy_in; grant SHALL be zero when avail = 0.
REQ-020 Round-robin: a one-hot pointer ptr gives highest priority to input ptr, then ptr+1, ..., wrapping modulo N_IN; grant is one-hot for the first requester in that order.
REQ-021 Grant is combinational (same cycle as request); ptr, lock and the watchdog update at the next edge.
REQ-022 On any grant to input g, ptr <= (g+1) mod N_IN; with no grant, ptr holds.
REQ-023 lock_next = (grant & HEAD) | (lock & ~(valid_in & TAIL & ~busy_in)); a SING grant never locks.
REQ-024 select = grant | (lock & valid_in).
REQ-025 want = (request | lock) & valid_in; not_accept = want & (~(grant|lock) | {N_IN{busy_in}}).
REQ-026 valid_out = |(lock & valid_in) | (|request & lock == 0).
REQ-027 shift_ctl = |grant.
REQ-028 A PAYL/TAIL from an unlocked input SHALL be ignored (want = 0, not_accept = 0).
REQ-029 A tail arriving while busy_in = 1 SHALL keep the lock; it is released only when accepted.
REQ-030 With N_IN = 1, ptr is constant and the input is granted whenever request & avail.

Reset
REQ-031 On rst = 1 at an edge: lock = 0, ptr = input 0, watchdog counter = 0, wdog_err = 0; a packet in progress is abandoned.
REQ-032 During reset, outputs remain combinational functions of the cleared state: select = grant, shift_ctl = |grant.

Configuration
REQ-033 Macro ALLOC_WATCHDOG_EN. When defined: a counter of width clog2(WDOG_CYC+1) increments each cycle lock != 0 and (valid_in & lock) == 0 or busy_in = 1, and clears when a locked flit is accepted or lock == 0; when it reaches WDOG_CYC, wdog_err sets and stays set until rst.
REQ-034 When ALLOC_WATCHDOG_EN is not defined: no counter is built and wdog_err is tied to 0.

Verification
REQ-035 N_IN=4, ptr=0: SING to which_port on inputs 1 and 3 in the same cycle -> grant=0010, shift_ctl=1; next cycle ptr=input 2, so input 3 wins the repeat.
REQ-036 HEAD on input 2, then 3 PAYL, then TAIL, with busy_in=0 -> lock_out=0100 from cycle 1 through the TAIL cycle, 0000 the cycle after; a HEAD on input 0 meanwhile sees not_accept[0]=1.
REQ-037 Locked input 1 presents TAIL with busy_in=1 for 3 cycles -> not_accept[1]=1 and lock held; busy_in=0 -> TAIL accepted and lock cleared next edge.
REQ-038 HEAD with dest != which_port -> request=0, valid_out=0, not_accept=0.
REQ-039 rst asserted mid-packet (lock=1000) -> lock_out=0000 and ptr=input 0 after the edge.
REQ-040 ALLOC_WATCHDOG_EN, WDOG_CYC=8: lock input 0, then hold valid_in[0]=0 -> wdog_err=1 after the 8th stalled cycle and stays 1 until rst.

Source files
------------

// File: rtl/allocator_rr_param_if.sv
// ---------------------------------------------------------------------------
// allocator_rr_param_if
//
// Bundles the switch-side signals of one output-port allocator.
//   master : the switch fabric (drives flits/valids/backpressure, observes
//            the allocator decisions)
//   slave  : the allocator itself
//
// Signals
//   which_port  PORT_W       ID of the output port served (static)
//   flit_in     N_IN*FLIT_W  input flits, input i at [i*FLIT_W +: FLIT_W]
//   valid_in    N_IN         per-input flit valid
//   busy_in     1            downstream output buffer full
//   select      N_IN         one-hot-or-zero crossbar mux select
//   valid_out   1            flit presented at the output port
//   not_accept  N_IN         per-input "flit not taken this cycle"
//   shift_ctl   1            new grant issued this cycle
//   lock_out    N_IN         registered packet-ownership vector
//   wdog_err    1            sticky watchdog error
// ---------------------------------------------------------------------------
interface allocator_rr_param_if #(
    parameter int N_IN   = 4,
    parameter int FLIT_W = 80,
    parameter int PORT_W = 2
);
    logic [PORT_W-1:0]      which_port;
    logic [N_IN*FLIT_W-1:0] flit_in;
    logic [N_IN-1:0]        valid_in;
    logic                   busy_in;
    logic [N_IN-1:0]        select;
    logic                   valid_out;
    logic [N_IN-1:0]        not_accept;
    logic                   shift_ctl;
    logic [N_IN-1:0]        lock_out;
    logic                   wdog_err;

    modport master (
        output which_port, flit_in, valid_in, busy_in,
        input  select, valid_out, not_accept, shift_ctl, lock_out, wdog_err
    );

    modport slave (
        input  which_port, flit_in, valid_in, busy_in,
        output select, valid_out, not_accept, shift_ctl, lock_out, wdog_err
    );
endinterface

// File: rtl/allocator_rr_param.sv
// ---------------------------------------------------------------------------
// allocator_rr_param
//
// Round-robin allocator for one NoC switch output port. Inputs whose head
// (or single-flit) packet targets this port request; a one-hot pointer
// rotates priority. A HEAD grant locks the port to that input until its
// TAIL is accepted downstream; SING grants never lock.
//
// Ports
//   clk   clock, rising edge
//   rst   synchronous, active-high reset
//   bus   allocator_rr_param_if.slave (see the interface file)
//
// Optional feature
//   ALLOC_WATCHDOG_EN  when defined, a stall counter sets the sticky
//                      wdog_err after WDOG_CYC consecutive stalled cycles
//                      of a locked packet; otherwise wdog_err is tied low.
//
// Flit-type codes come from noc_parameters.v (ENC_HEAD/PAYL/TAIL/SING);
// fallback values are defined here when that file is not in the build.
// ---------------------------------------------------------------------------
`ifndef ENC_HEAD
`define ENC_HEAD 2'b00
`endif
`ifndef ENC_PAYL
`define ENC_PAYL 2'b01
`endif
`ifndef ENC_TAIL
`define ENC_TAIL 2'b10
`endif
`ifndef ENC_SING
`define ENC_SING 2'b11
`endif

module allocator_rr_param #(
    parameter int N_IN     = 4,
    parameter int FLIT_W   = 80,
    parameter int FTYPE_W  = 2,
    parameter int PORT_W   = 2,
    parameter int WDOG_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    allocator_rr_param_if.slave  bus
);

    localparam int DW = 2 * N_IN;

    if (N_IN < 1 || N_IN > 16) begin : g_bad_n_in
        $error("allocator_rr_param: N_IN must be 1..16");
    end
    if (WDOG_CYC < 1 || WDOG_CYC > 65535) begin : g_bad_wdog
        $error("allocator_rr_param: WDOG_CYC must be 1..65535");
    end
    if (FLIT_W < FTYPE_W + PORT_W) begin : g_bad_flit
        $error("allocator_rr_param: FLIT_W too small for type and port fields");
    end

    logic [N_IN-1:0] lock_q, lock_d;
    logic [N_IN-1:0] ptr_q, ptr_d;

    logic [N_IN-1:0] is_head;
    logic [N_IN-1:0] is_tail;
    logic [N_IN-1:0] request;
    logic [N_IN-1:0] grant;
    logic [N_IN-1:0] want;
    logic [N_IN-1:0] ptr_rot;
    logic [N_IN-1:0] prio_mask;
    logic [DW-1:0]   dbl_req;
    logic [DW-1:0]   dbl_gnt;
    logic            avail;

    // Payload bits beyond the routing fields are not inspected here.
    logic            unused_flit_bits;
    assign unused_flit_bits = ^bus.flit_in;

    // -----------------------------------------------------------------------
    // Per-input decode
    // -----------------------------------------------------------------------
    for (genvar i = 0; i < N_IN; i++) begin : g_in
        logic [FTYPE_W-1:0] ftype;
        logic [PORT_W-1:0]  dest;
        logic               is_sing;

        assign ftype      = bus.flit_in[i*FLIT_W +: FTYPE_W];
        assign dest       = bus.flit_in[i*FLIT_W + FTYPE_W +: PORT_W];
        assign is_head[i] = (ftype == FTYPE_W'(`ENC_HEAD));
        assign is_tail[i] = (ftype == FTYPE_W'(`ENC_TAIL));
        assign is_sing    = (ftype == FTYPE_W'(`ENC_SING));
        assign request[i] = bus.valid_in[i] & (is_head[i] | is_sing)
                          & (dest == bus.which_port);

        // Pointer advances to the input just after the granted one.
        assign ptr_rot[(i + 1) % N_IN] = grant[i];
    end

    // -----------------------------------------------------------------------
    // Round-robin grant
    // The low half of dbl_req holds only requesters at or above the pointer;
    // the high half holds all requesters, so the lowest set bit of the
    // doubled vector is the first requester in wrap-around order.
    // -----------------------------------------------------------------------
    assign avail     = (lock_q == '0) & ~bus.busy_in;
    assign prio_mask = ~(ptr_q - N_IN'(1));
    assign dbl_req   = {request, request & prio_mask};
    assign dbl_gnt   = dbl_req & (~dbl_req + DW'(1));

    always_comb begin
        grant = '0;
        if (avail) begin
            grant = dbl_gnt[N_IN-1:0] | dbl_gnt[DW-1:N_IN];
        end
    end

    // -----------------------------------------------------------------------
    // Next state
    // A locked TAIL only releases the lock once it is actually taken
    // (busy_in low); a TAIL held off by backpressure keeps ownership.
    // -----------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (|grant) begin
            ptr_d = ptr_rot;
        end
    end

    assign lock_d = (grant & is_head)
                  | (lock_q & ~(bus.valid_in & is_tail & {N_IN{~bus.busy_in}}));

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= '0;
            ptr_q  <= N_IN'(1);
        end else begin
            lock_q <= lock_d;
            ptr_q  <= ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // PAYL/TAIL from an unlocked input never request and are not locked, so
    // they drop out of want and are neither accepted nor back-pressured.
    // -----------------------------------------------------------------------
    assign want           = (request | lock_q) & bus.valid_in;
    assign bus.select     = grant | (lock_q & bus.valid_in);
    assign bus.not_accept = want & (~(grant | lock_q) | {N_IN{bus.busy_in}});
    assign bus.valid_out  = (|(lock_q & bus.valid_in))
                          | ((|request) & (lock_q == '0));
    assign bus.shift_ctl  = |grant;
    assign bus.lock_out   = lock_q;

    // -----------------------------------------------------------------------
    // Watchdog
    // A locked packet is stalled whenever its owner presents nothing or the
    // downstream buffer is full; any accepted locked flit or an idle port
    // restarts the count. The counter saturates so wdog_err cannot re-arm.
    // -----------------------------------------------------------------------
`ifdef ALLOC_WATCHDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYC + 1);

    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             wd_err_q, wd_err_d;
    logic             stall;

    assign stall = (|lock_q) & (~(|(bus.valid_in & lock_q)) | bus.busy_in);

    always_comb begin
        wd_cnt_d = '0;
        wd_err_d = wd_err_q;
        if (stall) begin
            wd_cnt_d = wd_cnt_q;
            if (wd_cnt_q != CNT_W'(WDOG_CYC)) begin
                wd_cnt_d = wd_cnt_q + CNT_W'(1);
            end
            if (wd_cnt_q == CNT_W'(WDOG_CYC - 1)) begin
                wd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_err_d;
        end
    end

    assign bus.wdog_err = wd_err_q;
`else
    assign bus.wdog_err = 1'b0;
`endif

endmodule
